spi_read_sdc: RTL

SPI_READ_SDC -- requirements
Module: spi_read_sdc

---
 rtl/spi_read_sdc_pkg.sv | 42 ++++
 rtl/spi_read_sdc_byte.sv | 74 +++++++
 rtl/spi_read_sdc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_read_sdc_pkg.sv
// Shared definitions for the SD-card SPI single-block read engine.
package spi_read_sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_R1WAIT,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_TAIL,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_R1      = 2'd2,
    ERR_TOKEN   = 2'd3
  } err_t;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  localparam int         BLOCK_LEN   = 512;
  localparam int         CMD_LEN     = 6;
  localparam int         CRC_LEN     = 2;

  // Byte idx of the CMD17 frame; the trailing byte stands in for the CRC,
  // which the card ignores in SPI mode once initialised.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
    case (idx)
      3'd0:    cmd_byte = CMD17;
      3'd1:    cmd_byte = addr[31:24];
      3'd2:    cmd_byte = addr[23:16];
      3'd3:    cmd_byte = addr[15:8];
      3'd4:    cmd_byte = addr[7:0];
      default: cmd_byte = IDLE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/spi_read_sdc_byte.sv
// Mode-0 SPI byte transceiver: shifts one byte out MSB first while shifting
// one byte in. o_done fires in the cycle whose closing edge is the 8th
// rising SCK edge, with o_rx already holding the complete received byte.
module spi_byte_sdc
  import spi_read_sdc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic [7:0] o_rx,
  output logic       o_done,
  output logic       o_idle,
  output logic       o_sck,
  output logic       o_mosi
);

  logic       r_act;
  logic [7:0] r_div;
  logic [3:0] r_half;
  logic [7:0] r_sh;
  logic [7:0] r_rx;
  logic       r_sck;
  logic       r_mosi;
  logic       w_tick;

  assign w_tick = r_act && (r_div == 8'(CLK_DIV - 1));
  assign o_done = w_tick && (r_half == 4'd14);
  assign o_rx   = {r_rx[6:0], i_miso};
  assign o_idle = ~r_act;
  assign o_sck  = r_sck;
  assign o_mosi = r_mosi;

  // Half-period sequencer: even halves end on a rising edge (sample MISO),
  // odd halves end on a falling edge (present next MOSI bit).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act  <= 1'b0;
      r_div  <= 8'd0;
      r_half <= 4'd0;
      r_sh   <= 8'd0;
      r_rx   <= 8'd0;
      r_sck  <= 1'b0;
      r_mosi <= 1'b1;
    end else if (!r_act) begin
      if (i_we) begin
        r_act  <= 1'b1;
        r_sh   <= i_tx;
        r_mosi <= i_tx[7];
        r_div  <= 8'd0;
        r_half <= 4'd0;
      end
    end else if (w_tick) begin
      r_div  <= 8'd0;
      r_half <= r_half + 4'd1;
      r_sck  <= ~r_sck;
      if (!r_half[0]) begin
        r_rx <= {r_rx[6:0], i_miso};
      end else if (r_half == 4'd15) begin
        r_act  <= 1'b0;
        r_mosi <= 1'b1;
      end else begin
        r_sh   <= {r_sh[6:0], 1'b0};
        r_mosi <= r_sh[6];
      end
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

endmodule

// File: rtl/spi_read_sdc.sv
// SD-card (SDHC) single-block read over SPI: CMD17, R1 and data-token
// polling, 512-byte payload stream, CRC discard and a CS-high trailer byte.
module spi_read_sdc
  import spi_read_sdc_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int NCR_MAX   = 8,
  parameter int TOKEN_MAX = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic        i_init_done,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_cs,
  output logic        o_busy,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done,
  output logic [1:0]  o_err
);

  localparam int PMAX = (TOKEN_MAX > NCR_MAX) ? TOKEN_MAX : NCR_MAX;
  localparam int PW   = $clog2(PMAX) + 1;

  state_t        r_state, w_nxt;
  err_t          r_err, w_err_code;
  logic [31:0]   r_addr;
  logic          r_cs;
  logic          r_sent;
  logic [9:0]    r_dcnt;
  logic [PW-1:0] r_poll;
  logic [7:0]    r_data;
  logic          r_valid;

  logic          w_accept, w_we, w_set_err, w_cs_off;
  logic [7:0]    w_tx, w_rx;
  logic          w_bdone, w_idle;

  spi_byte_sdc #(.CLK_DIV(CLK_DIV)) u_byte (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_tx    (w_tx),
    .i_miso  (i_miso),
    .o_rx    (w_rx),
    .o_done  (w_bdone),
    .o_idle  (w_idle),
    .o_sck   (o_sck),
    .o_mosi  (o_mosi)
  );

  assign o_cs    = r_cs;
  assign o_busy  = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign o_done  = (r_state == ST_FIN);
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_err   = r_err;

  // Next-state and per-byte decisions; a byte is issued once the
  // transceiver is idle and none is outstanding in the current step.
  always_comb begin
    w_nxt      = r_state;
    w_accept   = 1'b0;
    w_we       = 1'b0;
    w_tx       = IDLE_BYTE;
    w_set_err  = 1'b0;
    w_err_code = ERR_OK;
    w_cs_off   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && i_init_done) begin
          w_accept = 1'b1;
          w_nxt    = ST_CMD;
        end
      end
      ST_CMD: begin
        w_tx = cmd_byte(r_dcnt[2:0], r_addr);
        w_we = w_idle && !r_sent;
        if (w_bdone && r_dcnt == 10'(CMD_LEN - 1)) w_nxt = ST_R1WAIT;
      end
      ST_R1WAIT: begin
        w_we = w_idle && !r_sent;
        if (w_bdone) begin
          if (w_rx != IDLE_BYTE) begin
            if (w_rx == 8'h00) begin
              w_nxt = ST_TOKEN;
            end else begin
              w_set_err  = 1'b1;
              w_err_code = ERR_R1;
              w_nxt      = ST_TAIL;
            end
          end else if (r_poll == PW'(NCR_MAX - 1)) begin
            w_set_err  = 1'b1;
            w_err_code = ERR_TIMEOUT;
            w_nxt      = ST_TAIL;
          end
        end
      end
      ST_TOKEN: begin
        w_we = w_idle && !r_sent;
        if (w_bdone) begin
          if (w_rx == TOKEN_START) begin
            w_nxt = ST_DATA;
          end else if (w_rx != IDLE_BYTE) begin
            w_set_err  = 1'b1;
            w_err_code = ERR_TOKEN;
            w_nxt      = ST_TAIL;
          end else if (r_poll == PW'(TOKEN_MAX - 1)) begin
            w_set_err  = 1'b1;
            w_err_code = ERR_TIMEOUT;
            w_nxt      = ST_TAIL;
          end
        end
      end
      ST_DATA: begin
        w_we = w_idle && !r_sent;
        if (w_bdone && r_dcnt == 10'(BLOCK_LEN - 1)) w_nxt = ST_CRC;
      end
      ST_CRC: begin
        w_we = w_idle && !r_sent;
        if (w_bdone && r_dcnt == 10'(CRC_LEN - 1)) w_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        // Wait for the previous byte to fully finish before raising CS,
        // then clock one idle byte with CS high; r_dcnt marks it sent.
        if (w_idle) begin
          if (!r_cs) w_cs_off = 1'b1;
          else if (r_dcnt == 10'd0 && !r_sent) w_we = 1'b1;
          else if (r_dcnt == 10'd1) w_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, counters, chip select, error code and payload strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_err   <= ERR_OK;
      r_addr  <= 32'd0;
      r_cs    <= 1'b1;
      r_sent  <= 1'b0;
      r_dcnt  <= 10'd0;
      r_poll  <= '0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= i_addr;
        r_err  <= ERR_OK;
        r_cs   <= 1'b0;
      end
      if (w_cs_off)  r_cs  <= 1'b1;
      if (w_set_err) r_err <= w_err_code;
      if (w_we)         r_sent <= 1'b1;
      else if (w_bdone) r_sent <= 1'b0;
      if (w_nxt != r_state) begin
        r_dcnt <= 10'd0;
        r_poll <= '0;
      end else if (w_bdone) begin
        r_dcnt <= r_dcnt + 10'd1;
        r_poll <= r_poll + 1'b1;
      end
      if (r_state == ST_DATA && w_bdone) begin
        r_valid <= 1'b1;
        r_data  <= w_rx;
      end
    end
  end

endmodule
